// File: rtl/fft_radix2_stage_stream.sv
// ---------------------------------------------------------------------------
// fft_radix2_stage_stream
//
// One streaming radix-2 FFT stage over an 8-sample complex frame. Each cycle
// it can accept a whole frame, apply the butterflies for pair distance SPAN
// with the matching twiddles, optionally halve the results, narrow them back
// to W bits, and present the frame two cycles later under valid/ready
// flow control.
//
// Parameters
//   N     : sample width W = 2**N bits per real/imag part (two's complement)
//   SPAN  : butterfly pair distance, 1, 2 or 4
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_r, in_i          : 8 input samples, x[k] at bits [k*W+W-1 : k*W]
//   in_valid, in_ready  : input handshake
//   scale               : halve this frame's outputs (captured with the frame)
//   out_r, out_i        : 8 output samples, packed like the inputs
//   out_valid, out_ready: output handshake
//   ovf_clr, ovf        : clear and sticky overflow flag
//
// Build option
//   FFT_STAGE_SAT_EN    : when defined, out-of-range results saturate;
//                         otherwise they wrap to their low W bits.
// ---------------------------------------------------------------------------
module fft_radix2_stage_stream #(
  parameter int N    = 4,
  parameter int SPAN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*(2**N)-1:0]   in_r,
  input  logic [8*(2**N)-1:0]   in_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  scale,
  output logic [8*(2**N)-1:0]   out_r,
  output logic [8*(2**N)-1:0]   out_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  ovf_clr,
  output logic                  ovf
);

  localparam int W   = 2**N;
  localparam int TW  = W + 1;   // twiddled value: -j can negate -2**(W-1)
  localparam int SW  = W + 2;   // butterfly sum
  localparam int PW  = SW + 9;  // product with the 9-bit signed constant 181
  localparam int GRP = 2 * SPAN;

  localparam logic signed [PW-1:0] C181 = PW'(181);  // round(256/sqrt(2))

  if (!(SPAN == 1 || SPAN == 2 || SPAN == 4)) begin : g_bad_span
    $error("fft_radix2_stage_stream: SPAN must be 1, 2 or 4");
  end

  // Multiply b by W_{2*SPAN}^kk; returns {tr, ti}. The 1/sqrt(2) factor is
  // applied after the sum so the floor happens exactly once per component.
  function automatic logic [2*TW-1:0] twiddle(input logic signed [W-1:0] br,
                                              input logic signed [W-1:0] bi,
                                              input int kk);
    logic signed [TW-1:0] sum_bb, dif_ib, tr, ti;
    logic signed [SW-1:0] neg_sum;
    logic signed [PW-1:0] p_sum, p_dif, p_neg;
    sum_bb  = TW'(br) + TW'(bi);
    dif_ib  = TW'(bi) - TW'(br);
    neg_sum = -SW'(sum_bb);
    p_sum   = PW'(sum_bb) * C181;
    p_dif   = PW'(dif_ib) * C181;
    p_neg   = PW'(neg_sum) * C181;
    tr      = TW'(br);
    ti      = TW'(bi);
    if ((SPAN == 2 && kk == 1) || (SPAN == 4 && kk == 2)) begin
      tr = TW'(bi);
      ti = -TW'(br);
    end else if (SPAN == 4 && kk == 1) begin
      tr = TW'(p_sum >>> 8);
      ti = TW'(p_dif >>> 8);
    end else if (SPAN == 4 && kk == 3) begin
      tr = TW'(p_dif >>> 8);
      ti = TW'(p_neg >>> 8);
    end
    return {tr, ti};
  endfunction

  // Optional halving, then narrowing to W bits; returns {overflow, value}.
  function automatic logic [W:0] narrow(input logic signed [SW-1:0] s,
                                        input logic halve);
    logic signed [SW-1:0] v;
    logic                 ov;
    logic [W-1:0]         val;
    v   = halve ? (s >>> 1) : s;
    // In range exactly when the bits above the W-bit sign bit copy it.
    ov  = !((v[SW-1:W-1] == '0) || (v[SW-1:W-1] == '1));
    val = v[W-1:0];
`ifdef FFT_STAGE_SAT_EN
    if (ov) val = v[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {ov, val};
  endfunction

  // Stage 1 state: the 'a' positions hold the sign-extended a, the 'b'
  // positions hold the twiddled t.
  logic                 s1_valid_q, s1_valid_d;
  logic signed [TW-1:0] s1_r_q [8];
  logic signed [TW-1:0] s1_r_d [8];
  logic signed [TW-1:0] s1_i_q [8];
  logic signed [TW-1:0] s1_i_d [8];
  logic                 s1_scale_q, s1_scale_d;

  // Stage 2 state
  logic                 out_valid_q, out_valid_d;
  logic [8*W-1:0]       out_r_q, out_r_d, out_i_q, out_i_d;
  logic                 ovf_q, ovf_d;

  logic                 s1_adv, s2_adv, ovf_set;
  logic signed [TW-1:0] tw_r [8];
  logic signed [TW-1:0] tw_i [8];
  logic [8*W-1:0]       y_r, y_i;
  logic                 any_ovf, is_sub;
  logic [2:0]           ia, ib;
  logic signed [SW-1:0] sum_r, sum_i;
  logic [W:0]           nr, ni;

  // Twiddle the incoming frame.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      if ((j % GRP) < SPAN) begin
        tw_r[j] = TW'($signed(in_r[j*W +: W]));
        tw_i[j] = TW'($signed(in_i[j*W +: W]));
      end else begin
        {tw_r[j], tw_i[j]} = twiddle($signed(in_r[j*W +: W]),
                                     $signed(in_i[j*W +: W]),
                                     (j % GRP) - SPAN);
      end
    end
  end

  // Butterfly sums out of stage 1, then scale and narrow.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    y_r = '0; y_i = '0; any_ovf = 1'b0;
    is_sub = 1'b0; ia = '0; ib = '0;
    sum_r = '0; sum_i = '0; nr = '0; ni = '0;
    for (int j = 0; j < 8; j++) begin
      is_sub = (j % GRP) >= SPAN;
      ia     = is_sub ? 3'(j - SPAN) : 3'(j);
      ib     = is_sub ? 3'(j) : 3'(j + SPAN);
      sum_r  = is_sub ? (SW'(s1_r_q[ia]) - SW'(s1_r_q[ib]))
                      : (SW'(s1_r_q[ia]) + SW'(s1_r_q[ib]));
      sum_i  = is_sub ? (SW'(s1_i_q[ia]) - SW'(s1_i_q[ib]))
                      : (SW'(s1_i_q[ia]) + SW'(s1_i_q[ib]));
      nr     = narrow(sum_r, s1_scale_q);
      ni     = narrow(sum_i, s1_scale_q);
      y_r[j*W +: W] = nr[W-1:0];
      y_i[j*W +: W] = ni[W-1:0];
      any_ovf = any_ovf | nr[W] | ni[W];
    end
  end

  // Flow control and next state.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_i_d     = s1_i_q;
    s1_scale_d = s1_scale_q;
    if (s1_adv && in_valid) begin
      s1_r_d     = tw_r;
      s1_i_d     = tw_i;
      s1_scale_d = scale;
    end

    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    if (s2_adv && s1_valid_q) begin
      out_r_d = y_r;
      out_i_d = y_i;
    end

    // Set has priority over clear.
    ovf_set = s2_adv && s1_valid_q && any_ovf;
    ovf_d   = ovf_set || (ovf_q && !ovf_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the stage-1 datapath is not reset; s1_valid_q qualifies it, so
  // leaving it out of reset keeps the wide registers free of reset routing.
  always_ff @(posedge clk) begin
    s1_r_q     <= s1_r_d;
    s1_i_q     <= s1_i_d;
    s1_scale_q <= s1_scale_d;
  end

  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_radix2_stage_stream.sv
// ---------------------------------------------------------------------------
// tb_fft_radix2_stage_stream
//
// Drives three instances (SPAN = 1, 2, 4; N = 4) with the same stimulus.
// A reference model computes each accepted frame's result, which is queued
// per instance and compared when that instance emits a frame. Fixed vectors
// with hand-derived results, plus directed back-pressure, reset and overflow
// clear sequences, cover the corner cases.
// ---------------------------------------------------------------------------
module tb_fft_radix2_stage_stream;

  typedef struct {
    logic [127:0] r;
    logic [127:0] i;
    logic         ovf;
  } frame_t;

  typedef struct {
    int           d;      // instance index: 0 -> SPAN 1, 1 -> SPAN 2, 2 -> SPAN 4
    logic [127:0] xr;
    logic [127:0] xi;
    logic         sc;
    logic [127:0] er;
    logic [127:0] ei;
    logic         eovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, scale, out_ready, ovf_clr;
  logic [127:0] in_r, in_i;
  logic [127:0] o_r [3];
  logic [127:0] o_i [3];
  logic         o_valid [3];
  logic         o_ovf [3];
  logic         i_ready [3];

  int     checks = 0;
  int     failures = 0;
  int     fires;
  logic   acc;
  frame_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  fft_radix2_stage_stream #(.N(4), .SPAN(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
    .in_ready(i_ready[0]), .scale(scale), .out_r(o_r[0]), .out_i(o_i[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf(o_ovf[0]));

  fft_radix2_stage_stream #(.N(4), .SPAN(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
    .in_ready(i_ready[1]), .scale(scale), .out_r(o_r[1]), .out_i(o_i[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf(o_ovf[1]));

  fft_radix2_stage_stream #(.N(4), .SPAN(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
    .in_ready(i_ready[2]), .scale(scale), .out_r(o_r[2]), .out_i(o_i[2]),
    .out_valid(o_valid[2]), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf(o_ovf[2]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int v0, input int v1, input int v2, input int v3,
                                      input int v4, input int v5, input int v6, input int v7);
    return {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  function automatic longint smp(input logic [127:0] x, input int idx);
    logic signed [15:0] s;
    s = x[idx*16 +: 16];
    return longint'(s);
  endfunction

  function automatic logic [16:0] nar(input longint v, input logic sc);
    logic [63:0] u;
    logic [15:0] val;
    logic        o;
    if (sc) v = v >>> 1;
    o   = (v > 32767) || (v < -32768);
    u   = v;
    val = u[15:0];
`ifdef FFT_STAGE_SAT_EN
    if (v > 32767) val = 16'h7fff;
    else if (v < -32768) val = 16'h8000;
`endif
    return {o, val};
  endfunction

  function automatic frame_t model(input int span, input logic [127:0] xr,
                                   input logic [127:0] xi, input logic sc);
    frame_t      f;
    longint      ar, ai, br, bi, tr, ti;
    logic [16:0] t;
    f.r = '0; f.i = '0; f.ovf = 1'b0;
    for (int g = 0; g < 8; g += 2*span) begin
      for (int k = 0; k < span; k++) begin
        ar = smp(xr, g+k);      ai = smp(xi, g+k);
        br = smp(xr, g+k+span); bi = smp(xi, g+k+span);
        if (k == 0) begin
          tr = br; ti = bi;
        end else if (span == 2 || k == 2) begin
          tr = bi; ti = -br;
        end else if (k == 1) begin
          tr = ((br + bi) * 181) >>> 8; ti = ((bi - br) * 181) >>> 8;
        end else begin
          tr = ((bi - br) * 181) >>> 8; ti = (-(br + bi) * 181) >>> 8;
        end
        t = nar(ar + tr, sc); f.r[(g+k)*16 +: 16] = t[15:0];      f.ovf |= t[16];
        t = nar(ai + ti, sc); f.i[(g+k)*16 +: 16] = t[15:0];      f.ovf |= t[16];
        t = nar(ar - tr, sc); f.r[(g+k+span)*16 +: 16] = t[15:0]; f.ovf |= t[16];
        t = nar(ai - ti, sc); f.i[(g+k+span)*16 +: 16] = t[15:0]; f.ovf |= t[16];
      end
    end
    return f;
  endfunction

  task automatic sb_push(input int d, input frame_t f);
    case (d)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic sb_pop(input int d);
    frame_t e;
    logic   have;
    have = 1'b0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      check($sformatf("sb_unexpected_s%0d", 1 << d), 128'd1, 128'd0);
    end else begin
      check($sformatf("sb_r_s%0d", 1 << d), o_r[d], e.r);
      check($sformatf("sb_i_s%0d", 1 << d), o_i[d], e.i);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the
  // rising edge. Inputs are changed by the caller after this returns.
  task automatic cycle();
    @(negedge clk);
    acc = in_valid && i_ready[1] && !rst;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (o_valid[d] && out_ready) begin
          if (d == 1) fires++;
          sb_pop(d);
        end
        if (in_valid && i_ready[d]) sb_push(d, model(1 << d, in_r, in_i, scale));
      end
    end
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end
    #1;
  endtask

  vec_t         vt [6];
  logic [127:0] fr_r [4];
  logic [127:0] fr_i [4];
  logic [127:0] hold_r;
  int           idx, lat, sent;
  int           sat_pos, sat_neg;

  initial begin
`ifdef FFT_STAGE_SAT_EN
    sat_pos = 32767;  sat_neg = -32768;
`else
    sat_pos = -2;     sat_neg = 0;
`endif
    vt[0] = '{1, pk(1,2,3,4,5,6,7,8), '0, 1'b0,
              pk(4,2,-2,2,12,6,-2,6), pk(0,-4,0,4,0,-8,0,8), 1'b0};
    vt[1] = '{2, pk(0,0,0,0,0,1000,0,0), '0, 1'b0,
              pk(0,707,0,0,0,-707,0,0), pk(0,-708,0,0,0,708,0,0), 1'b0};
    vt[2] = '{2, pk(0,0,0,0,0,0,1000,1000), '0, 1'b0,
              pk(0,0,0,-708,0,0,0,708), pk(0,0,-1000,-708,0,0,1000,708), 1'b0};
    vt[3] = '{0, pk(32767,32767,0,0,0,0,0,0), '0, 1'b0,
              pk(sat_pos,0,0,0,0,0,0,0), '0, 1'b1};
    vt[4] = '{0, pk(32767,32767,0,0,0,0,0,0), '0, 1'b1,
              pk(32767,0,0,0,0,0,0,0), '0, 1'b1};
    vt[5] = '{1, pk(-32768,0,-32768,0,0,0,0,0), '0, 1'b0,
              pk(sat_neg,0,0,0,0,0,0,0), '0, 1'b1};

    // Reset
    rst = 1'b1; in_valid = 1'b0; scale = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    in_r = '0; in_i = '0; fires = 0;
    #1;
    cycle(); cycle();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_valid_s%0d", 1 << d), 128'(o_valid[d]), 128'd0);
      check($sformatf("reset_ovf_s%0d", 1 << d), 128'(o_ovf[d]), 128'd0);
      check($sformatf("reset_out_r_s%0d", 1 << d), o_r[d], '0);
    end
    rst = 1'b0;
    check("reset_in_ready", 128'(i_ready[1]), 128'd1);

    // Table-driven vectors: single frames, latency and exact results.
    for (int v = 0; v < 6; v++) begin
      in_r = vt[v].xr; in_i = vt[v].xi; scale = vt[v].sc; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0; in_r = '0; in_i = '0; scale = 1'b0;
      lat = 1;
      while (!o_valid[vt[v].d] && lat < 6) begin
        cycle();
        lat++;
      end
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'd2);
      check($sformatf("vec%0d_out_r", v), o_r[vt[v].d], vt[v].er);
      check($sformatf("vec%0d_out_i", v), o_i[vt[v].d], vt[v].ei);
      check($sformatf("vec%0d_ovf", v), 128'(o_ovf[vt[v].d]), 128'(vt[v].eovf));
      cycle();
    end

    // Back-pressure: four frames offered while the sink stalls for 6 cycles.
    for (int f = 0; f < 4; f++) begin
      fr_r[f] = {$urandom, $urandom, $urandom, $urandom} & {8{16'h0fff}};
      fr_i[f] = {$urandom, $urandom, $urandom, $urandom} & {8{16'h0fff}};
    end
    out_ready = 1'b0; idx = 0; hold_r = '0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_r = fr_r[idx]; in_i = fr_i[idx]; end
      cycle();
      if (acc) idx++;
      if (c == 2) hold_r = o_r[1];
    end
    check("bp_accepted", 128'(idx), 128'd2);
    check("bp_in_ready", 128'(i_ready[1]), 128'd0);
    check("bp_valid", 128'(o_valid[1]), 128'd1);
    check("bp_hold", o_r[1], hold_r);
    out_ready = 1'b1; fires = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_r = fr_r[idx]; in_i = fr_i[idx]; end
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 128'(idx), 128'd4);
    check("bp_fires", 128'(fires), 128'd4);

    // Random traffic against the scoreboard.
    sent = 0;
    for (int c = 0; c < 400 && sent < 30; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      scale     = $urandom_range(0, 1);
      in_r = {$urandom, $urandom, $urandom, $urandom};
      in_i = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1; scale = 1'b0;
    repeat (6) cycle();
    check("rand_sent", 128'(sent), 128'd30);
    check("sb_drain", 128'(q0.size() + q1.size() + q2.size()), 128'd0);

    // Reset with two frames in flight and ovf set.
    out_ready = 1'b0; in_valid = 1'b1; in_r = vt[3].xr; in_i = '0;
    cycle(); cycle();
    check("rst_pre_ovf", 128'(o_ovf[0]), 128'd1);
    rst = 1'b1; out_ready = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid_s%0d", 1 << d), 128'(o_valid[d]), 128'd0);
      check($sformatf("rst_ovf_s%0d", 1 << d), 128'(o_ovf[d]), 128'd0);
    end
    check("rst_in_ready", 128'(i_ready[1]), 128'd1);
    fires = 0;
    repeat (5) cycle();
    check("rst_no_stale", 128'(fires), 128'd0);

    // Overflow clear in the same cycle an overflowing frame enters S2.
    in_valid = 1'b1; in_r = vt[3].xr; in_i = '0; scale = 1'b0;
    cycle();
    in_valid = 1'b0; ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("clr_set_wins", 128'(o_ovf[0]), 128'd1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("clr_clears", 128'(o_ovf[0]), 128'd0);
    repeat (3) cycle();
    check("final_drain", 128'(q0.size() + q1.size() + q2.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_radix2_stage_stream.md
FFT_RADIX2_STAGE_STREAM -- requirements
Module: fft_radix2_stage_stream

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning sample width W = 2**N bits (signed two's complement, per real/imag part).
REQ-002 The block SHALL have parameter SPAN, default 2, meaning butterfly pair distance (legal 1, 2, 4); other values SHALL fail elaboration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports in_r and in_i, input, 8*W bits: 8 complex samples, x[k] at bits [k*W+W-1 : k*W].
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-007 The block SHALL have port scale, input, 1 bit: halve this frame's outputs; sampled with the frame.
REQ-008 The block SHALL have ports out_r and out_i, output, 8*W bits, packed as in_r/in_i.
REQ-009 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 The block SHALL have port ovf_clr, input, 1 bit, and port ovf, output, 1 bit: sticky overflow flag and its clear.

Function
REQ-011 A frame SHALL transfer on a cycle with in_valid and in_ready both high; an output frame SHALL transfer when out_valid and out_ready are both high.
REQ-012 Butterflies: for each group base g (multiple of 2*SPAN) and k in 0..SPAN-1: a=x[g+k], b=x[g+k+SPAN], t=b*W_{2*SPAN}^k; y[g+k]=a+t, y[g+k+SPAN]=a-t.
REQ-013 Twiddles: k=0 -> 1. SPAN=2, k=1 -> -j (tr=bi, ti=-br). SPAN=4: k=2 -> -j; k=1 -> tr=((br+bi)*181)>>>8, ti=((bi-br)*181)>>>8; k=3 -> tr=((bi-br)*181)>>>8, ti=(-(br+bi)*181)>>>8.
REQ-014 In REQ-013, >>> is an arithmetic right shift (floor); intermediate sums SHALL be W+1 bits, products wide enough never to lose bits before the shift.
REQ-015 Butterfly sums SHALL be W+2 bits wide; if the frame's scale=1, each sum SHALL be arithmetic-shifted right by 1 (floor) before narrowing.
REQ-016 Narrowing to W bits: a value outside [-2**(W-1), 2**(W-1)-1] is an overflow; the result SHALL be handled per REQ-024.
REQ-017 Pipeline: 2 register stages (S1: twiddle products registered with a and scale; S2: narrowed outputs registered). Latency SHALL be 2 cycles from input transfer to out_valid with no stall.
REQ-018 Flow control: S2 advances when !out_valid || out_ready; S1 advances when S1 is empty or S2 advances; in_ready = S1 empty || S2 advances. Bubbles SHALL collapse; throughput SHALL be 1 frame/cycle with out_ready held high.
REQ-019 While out_valid=1 and out_ready=0, out_r/out_i SHALL hold stable; frames SHALL never be dropped, duplicated, or reordered.
REQ-020 ovf SHALL be set on the cycle after any element of a frame entering S2 overflows, and SHALL stay set until ovf_clr or rst; if set and ovf_clr occur in the same cycle, set SHALL win.

Reset
REQ-021 On rst=1 at a clock edge: S1/S2 valids SHALL clear (in-flight frames discarded), out_valid=0, ovf=0, out_r=out_i=0.
REQ-022 in_ready SHALL be 1 in the first cycle after reset deasserts; rst SHALL override any simultaneous handshake.

Configuration
REQ-023 The block SHALL use macro FFT_STAGE_SAT_EN.
REQ-024 With FFT_STAGE_SAT_EN defined, overflowed values SHALL saturate to 2**(W-1)-1 or -2**(W-1); without it, they SHALL wrap (keep low W bits); ovf behaves identically in both builds.

Verification (N=4, W=16)
REQ-025 SPAN=2, x=1..8 real, scale=0 -> out0=4, out2=-2, out1=2-4j, out3=2+4j, out4=12, out6=-2, out5=6-8j, out7=6+8j; ovf=0; latency 2.
REQ-026 SPAN=4, x5=1000 real, others 0 -> out1=707-708j, out5=-707+708j, all other outputs 0.
REQ-027 SPAN=1, x0=x1=32767, scale=0 -> out0=32767 (SAT_EN) or -2 (no SAT_EN), out1=0, ovf=1; the same input with scale=1 -> out0=32767, ovf unchanged by this frame.
REQ-028 Push 4 frames back-to-back with out_ready=0 for 6 cycles -> in_ready low after 2 frames accepted; on release, frames emerge in order, one per cycle, none lost.
REQ-029 Assert rst with 2 frames in flight and ovf=1 -> next cycle out_valid=0, ovf=0, in_ready=1; no stale frame appears afterwards.
REQ-030 Assert ovf_clr in the same cycle an overflowing frame enters S2 -> ovf=1.
